// File: rtl/store_buffer_if.sv
// store_buffer_if
// Bundles the store-side, memory-side and load-probe signals of the store
// buffer so the buffer and its neighbours connect through one port.
//   DEPTH       : FIFO entries (power of two, >= 2); sets the width of count.
//   master      : the core/memory side (drives stores, mem_ack, ld_addr).
//   slave       : the store buffer itself.
// Handshakes:
//   store side  : a store is taken on a rising edge where st_valid && st_ready
//                 and the size/alignment is legal; st_ready depends only on
//                 the registered count, never on st_valid.
//   memory side : an entry retires on a rising edge where mem_req && mem_ack;
//                 mem_addr/mem_wdata/mem_wstrb stay stable while mem_req is
//                 high and mem_ack is low. mem_ack is ignored when mem_req is low.
interface store_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          st_valid;
  logic [31:0]   st_addr;
  logic [31:0]   st_data;
  logic          sb_en;
  logic          sh_en;
  logic          sw_en;
  logic          st_ready;
  logic          st_misalign;
  logic          mem_req;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ack;
  logic [31:0]   ld_addr;
  logic          ld_hazard;
  logic          empty;
  logic [CW-1:0] count;

  modport master (
    output st_valid, st_addr, st_data, sb_en, sh_en, sw_en, mem_ack, ld_addr,
    input  st_ready, st_misalign, mem_req, mem_addr, mem_wdata, mem_wstrb,
           ld_hazard, empty, count
  );

  modport slave (
    input  st_valid, st_addr, st_data, sb_en, sh_en, sw_en, mem_ack, ld_addr,
    output st_ready, st_misalign, mem_req, mem_addr, mem_wdata, mem_wstrb,
           ld_hazard, empty, count
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer
// Posted-write buffer between execute and the data-memory write port. Each
// legal store is placed into its word lane with a byte strobe and queued in
// a DEPTH-entry FIFO; a two-state drain FSM retires entries over req/ack.
// Ports:
//   clk          : rising-edge clock
//   rst          : synchronous, active-high reset
//   bus          : store_buffer_if.slave (store, memory and load-probe signals)
//   dbg_state_o  : drain FSM state (0 = IDLE, 1 = ISSUE)
// Optional feature: define STORE_BUF_LD_HAZARD_EN to build one address
// comparator per entry driving ld_hazard; otherwise ld_hazard is tied 0.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  store_buffer_if.slave  bus,
  output logic           dbg_state_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [29:0]        addr_q [DEPTH];
  logic [31:0]        data_q [DEPTH];
  logic [3:0]         strb_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               empty_q;
  logic               misalign_q, misalign_d;
  logic               st_ready, legal, push, pop;
  logic [31:0]        lane_data;
  logic [3:0]         lane_strb;
  logic [4:0]         shamt;

  // Store acceptance and lane placement
  always_comb begin
    st_ready   = (count_q < DEPTH_C);
    legal      = $onehot({bus.sb_en, bus.sh_en, bus.sw_en}) &&
                 (bus.sb_en ||
                  (bus.sh_en && !bus.st_addr[0]) ||
                  (bus.sw_en && (bus.st_addr[1:0] == 2'b00)));
    push       = bus.st_valid && st_ready && legal;
    misalign_d = bus.st_valid && st_ready && !legal;
    pop        = (state_q == ISSUE) && bus.mem_ack;

    shamt      = {bus.st_addr[1:0], 3'b000};
    lane_data  = '0;
    lane_strb  = '0;
    if (bus.sw_en) begin
      lane_data = bus.st_data;
      lane_strb = 4'b1111;
    end else if (bus.sh_en) begin
      lane_data = {16'h0000, bus.st_data[15:0]} << shamt;
      lane_strb = 4'b0011 << bus.st_addr[1:0];
    end else if (bus.sb_en) begin
      lane_data = {24'h000000, bus.st_data[7:0]} << shamt;
      lane_strb = 4'b0001 << bus.st_addr[1:0];
    end
  end

  // Pointer/count bookkeeping and drain FSM
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = ISSUE;
      // count_d already accounts for a push in the same cycle as the pop
      ISSUE:   if (pop && (count_d == '0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= (count_d == '0);
      misalign_q <= misalign_d;
    end
  end

  // Entry storage needs no reset: validity is tracked by the pointers/count
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      addr_q[wr_ptr_q] <= bus.st_addr[31:2];
      data_q[wr_ptr_q] <= lane_data;
      strb_q[wr_ptr_q] <= lane_strb;
    end
  end

  // Memory side is driven from the head entry only while issuing
  always_comb begin
    bus.mem_req   = (state_q == ISSUE);
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    if (state_q == ISSUE) begin
      bus.mem_addr  = {addr_q[rd_ptr_q], 2'b00};
      bus.mem_wdata = data_q[rd_ptr_q];
      bus.mem_wstrb = strb_q[rd_ptr_q];
    end
  end

  assign bus.st_ready    = st_ready;
  assign bus.st_misalign = misalign_q;
  assign bus.count       = count_q;
  assign bus.empty       = empty_q;
  assign dbg_state_o     = state_q;

`ifdef STORE_BUF_LD_HAZARD_EN
  logic             hazard;
  logic [PTR_W-1:0] rel;
  logic             unused_ld_lo;

  // An entry is live when its distance from the read pointer is below count
  always_comb begin
    hazard = 1'b0;
    rel    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = PTR_W'(i) - rd_ptr_q;
      if (({1'b0, rel} < count_q) && (addr_q[i] == bus.ld_addr[31:2]))
        hazard = 1'b1;
    end
  end

  assign bus.ld_hazard = hazard;
  assign unused_ld_lo  = ^bus.ld_addr[1:0];
`else
  logic unused_ld;
  assign bus.ld_hazard = 1'b0;
  assign unused_ld     = ^bus.ld_addr;
`endif
endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam logic [2:0] SB = 3'b100;
  localparam logic [2:0] SH = 3'b010;
  localparam logic [2:0] SW = 3'b001;
`ifdef STORE_BUF_LD_HAZARD_EN
  localparam logic [31:0] HZ = 32'd1;
`else
  localparam logic [31:0] HZ = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // expected memory writes: {mem_addr, mem_wdata, mem_wstrb}
  logic [67:0] exp_q[$];

  store_buffer_if #(.DEPTH(DEPTH)) bus ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_store(input logic [2:0] sz, input logic [31:0] addr,
                             input logic [31:0] data);
    bus.st_valid = 1'b1;
    {bus.sb_en, bus.sh_en, bus.sw_en} = sz;
    bus.st_addr  = addr;
    bus.st_data  = data;
  endtask

  task automatic idle_store();
    bus.st_valid = 1'b0;
    {bus.sb_en, bus.sh_en, bus.sw_en} = 3'b000;
    bus.st_addr  = '0;
    bus.st_data  = '0;
  endtask

  task automatic expect_write(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb);
    exp_q.push_back({addr, wdata, strb});
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && bus.mem_req && bus.mem_ack) begin
      logic [67:0] e;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL mem_write_unexpected: got addr 0x%08h data 0x%08h strb %b, expected none",
                 bus.mem_addr, bus.mem_wdata, bus.mem_wstrb);
      end else begin
        e = exp_q.pop_front();
        if ({bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== e) begin
          tests_failed++;
          $display("FAIL mem_write: got addr 0x%08h data 0x%08h strb %b, expected addr 0x%08h data 0x%08h strb %b",
                   bus.mem_addr, bus.mem_wdata, bus.mem_wstrb, e[67:36], e[35:4], e[3:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    idle_store();
    bus.mem_ack = 1'b0;
    bus.ld_addr = '0;
    rst = 1'b1;
    step();
    step();
    @(negedge clk);
    check("rst_st_ready",  32'(bus.st_ready), 32'd1);
    check("rst_misalign",  32'(bus.st_misalign), 32'd0);
    check("rst_mem_req",   32'(bus.mem_req), 32'd0);
    check("rst_mem_addr",  bus.mem_addr, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata, 32'd0);
    check("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    check("rst_ld_hazard", 32'(bus.ld_hazard), 32'd0);
    check("rst_empty",     32'(bus.empty), 32'd1);
    check("rst_count",     32'(bus.count), 32'd0);
    step();
    rst = 1'b0;

    // sb into top byte lane of an empty buffer
    drive_store(SB, 32'h0000_1003, 32'h0000_00AB);
    expect_write(32'h0000_1000, 32'hAB00_0000, 4'b1000);
    step();
    idle_store();
    @(negedge clk);
    check("lat_count_e0", 32'(bus.count), 32'd1);
    check("lat_empty_e0", 32'(bus.empty), 32'd0);
    check("lat_req_e0",   32'(bus.mem_req), 32'd0);
    step();
    bus.mem_ack = 1'b1;
    @(negedge clk);
    check("lat_req_e1",   32'(bus.mem_req), 32'd1);
    check("sb_mem_addr",  bus.mem_addr, 32'h0000_1000);
    check("sb_mem_wdata", bus.mem_wdata, 32'hAB00_0000);
    check("sb_mem_wstrb", 32'(bus.mem_wstrb), 32'b1000);
    step();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check("sb_count_after_pop", 32'(bus.count), 32'd0);
    check("sb_empty_after_pop", 32'(bus.empty), 32'd1);
    check("sb_req_after_pop",   32'(bus.mem_req), 32'd0);

    // misaligned sh, then an illegal double size select
    drive_store(SH, 32'h0000_2001, 32'h0000_1234);
    step();
    idle_store();
    @(negedge clk);
    check("mis_sh_pulse", 32'(bus.st_misalign), 32'd1);
    check("mis_sh_count", 32'(bus.count), 32'd0);
    check("mis_sh_req",   32'(bus.mem_req), 32'd0);
    step();
    @(negedge clk);
    check("mis_sh_pulse_end", 32'(bus.st_misalign), 32'd0);
    drive_store(SB | SW, 32'h0000_2000, 32'h0000_5678);
    step();
    idle_store();
    @(negedge clk);
    check("mis_multi_pulse", 32'(bus.st_misalign), 32'd1);
    check("mis_multi_count", 32'(bus.count), 32'd0);
    check("mis_multi_req",   32'(bus.mem_req), 32'd0);
    step();
    @(negedge clk);
    check("mis_multi_pulse_end", 32'(bus.st_misalign), 32'd0);

    // lane placement, streamed with mem_ack held high
    bus.mem_ack = 1'b1;
    drive_store(SH, 32'h0000_4002, 32'h0000_BEEF);
    expect_write(32'h0000_4000, 32'hBEEF_0000, 4'b1100);
    step();
    drive_store(SB, 32'h0000_4001, 32'h0000_005A);
    expect_write(32'h0000_4000, 32'h0000_5A00, 4'b0010);
    step();
    drive_store(SH, 32'h0000_4000, 32'h0000_1234);
    expect_write(32'h0000_4000, 32'h0000_1234, 4'b0011);
    step();
    idle_store();
    step();
    step();
    @(negedge clk);
    check("lanes_count_drained", 32'(bus.count), 32'd0);
    check("lanes_req_idle",      32'(bus.mem_req), 32'd0);
    step();
    bus.mem_ack = 1'b0;

    // fill: five sw pushes, only four fit
    for (int k = 1; k <= 5; k++) begin
      drive_store(SW, 32'h0000_0100 + 32'((k - 1) * 4), 32'(k));
      if (k <= 4) expect_write(32'h0000_0100 + 32'((k - 1) * 4), 32'(k), 4'b1111);
      step();
    end
    // full: push attempt with mem_ack -> pop only
    drive_store(SW, 32'h0000_0114, 32'd6);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    check("full_count",    32'(bus.count), 32'd4);
    check("full_st_ready", 32'(bus.st_ready), 32'd0);
    check("full_mem_req",  32'(bus.mem_req), 32'd1);
    step();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check("full_pop_only_count", 32'(bus.count), 32'd3);
    check("full_ready_again",    32'(bus.st_ready), 32'd1);
    expect_write(32'h0000_0114, 32'd6, 4'b1111);
    step();
    idle_store();
    @(negedge clk);
    check("refill_count",    32'(bus.count), 32'd4);
    check("refill_st_ready", 32'(bus.st_ready), 32'd0);
    step();
    bus.mem_ack = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("drain_req_no_bubble", 32'(bus.mem_req), 32'd1);
      check("drain_count",         32'(bus.count), 32'(5 - k));
      step();
    end
    @(negedge clk);
    check("drain_done_count", 32'(bus.count), 32'd0);
    check("drain_done_req",   32'(bus.mem_req), 32'd0);
    step();
    bus.mem_ack = 1'b0;

    // reset while issuing with three entries held
    for (int k = 0; k < 3; k++) begin
      drive_store(SW, 32'h0000_0200 + 32'(k * 4), 32'hF0 + 32'(k));
      step();
    end
    idle_store();
    @(negedge clk);
    check("prerst_count", 32'(bus.count), 32'd3);
    check("prerst_req",   32'(bus.mem_req), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_req",      32'(bus.mem_req), 32'd0);
    check("midrst_count",    32'(bus.count), 32'd0);
    check("midrst_empty",    32'(bus.empty), 32'd1);
    check("midrst_st_ready", 32'(bus.st_ready), 32'd1);

    // load hazard probe
    bus.ld_addr = 32'h0000_3002;
    drive_store(SW, 32'h0000_3000, 32'h0000_CAFE);
    expect_write(32'h0000_3000, 32'h0000_CAFE, 4'b1111);
    step();
    idle_store();
    @(negedge clk);
    check("hz_hit_pending", 32'(bus.ld_hazard), HZ);
    bus.ld_addr = 32'h0000_3008;
    #1;
    check("hz_other_word", 32'(bus.ld_hazard), 32'd0);
    bus.ld_addr = 32'h0000_3002;
    step();
    bus.mem_ack = 1'b1;
    @(negedge clk);
    check("hz_hit_issue", 32'(bus.ld_hazard), HZ);
    step();
    bus.mem_ack = 1'b0;
    @(negedge clk);
    check("hz_after_retire", 32'(bus.ld_hazard), 32'd0);
    check("hz_count",        32'(bus.count), 32'd0);

    step();
    step();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-write buffer downstream of the store-data formatter, between the execute stage and the data-memory write port. Each accepted store is aligned into its word lane and given a byte strobe, then queued in a DEPTH-entry FIFO. The queue drains one entry at a time over a req/ack handshake, so the core does not wait on memory write latency. An optional comparator flags loads that hit a pending store word.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- st_valid  in  1  store offered this cycle
- st_addr  in  32  byte address
- st_data  in  32  store data from formatter, right-justified and zero-extended
- sb_en, sh_en, sw_en  in  1 each  size select; exactly one high for a legal store
- st_ready  out  1  buffer can accept a store
- st_misalign  out  1  one-cycle pulse: store rejected
- mem_req  out  1  write request to data memory
- mem_addr  out  32  word address, bits [1:0] = 0
- mem_wdata  out  32  lane-aligned write data
- mem_wstrb  out  4  byte strobes; bit i enables byte lane i
- mem_ack  in  1  memory accepted the current request
- ld_addr  in  32  address of the load in execute
- ld_hazard  out  1  load word matches a pending store
- empty  out  1  no entries held
- count  out  $clog2(DEPTH)+1  entries held

## Operation
- Push condition: st_valid && st_ready && legal.
  - legal = exactly one size enable set, and the address is aligned: sh requires st_addr[0]=0; sw requires st_addr[1:0]=0.
- st_misalign is registered. It pulses for one cycle, on the cycle after st_valid && st_ready && !legal. Nothing is written.
- Lane placement, with o = st_addr[1:0]:
  - sb: wdata = st_data[7:0] << 8·o; wstrb = 4'b0001 << o
  - sh: wdata = st_data[15:0] << 8·o; wstrb = 4'b0011 << o
  - sw: wdata = st_data; wstrb = 4'b1111
  - Unselected lanes are 0.
- Entry contents: {st_addr[31:2], wdata, wstrb}. The write pointer wraps modulo DEPTH.
- st_ready = (count < DEPTH). Computed from the current count only; no same-cycle pass-through when full.
- Drain FSM:
  - IDLE: mem_req = 0. If count ≠ 0, go to ISSUE at the next edge.
  - ISSUE: mem_req = 1. mem_addr, mem_wdata and mem_wstrb come combinationally from the head entry.
    - mem_ack = 0: stay in ISSUE; outputs held stable.
    - mem_ack = 1: pop the head (read pointer wraps). Stay in ISSUE if count after pop ≠ 0, otherwise go to IDLE.
- mem_ack is ignored while mem_req = 0.
- Simultaneous push and pop: count is unchanged and both pointers advance. Entries drain strictly in FIFO order.
- Stores to the same word are never merged.

## Timing
- Reset values: st_ready = 1, st_misalign = 0, mem_req = 0, mem_addr/mem_wdata/mem_wstrb = 0, ld_hazard = 0, empty = 1, count = 0; FSM in IDLE; pointers = 0.
- Reset mid-operation: all queued entries are discarded and any in-flight request is abandoned. mem_req is 0 from the cycle after the reset edge.
- Latency into an empty buffer:
  - push at edge E0
  - count = 1 and empty = 0 after E0
  - FSM enters ISSUE at E1, so mem_req rises after E1
- Back-to-back drain: with mem_ack held high, one entry retires per cycle and mem_req stays high with no bubble.
- Full buffer: st_ready = 0 until the cycle after a pop.
- count and empty are registered. ld_hazard is combinational from ld_addr and the stored entries.

## Configuration
- STORE_BUF_LD_HAZARD_EN defined:
  - One comparator per entry is built.
  - ld_hazard = 1 if any valid entry has addr[31:2] == ld_addr[31:2]. The head entry in ISSUE counts as valid until popped.
- STORE_BUF_LD_HAZARD_EN undefined:
  - No comparators are built.
  - ld_hazard is tied 0; the port remains.

## Test plan
- Reset, then sb to address 0x0000_1003 with st_data 0x0000_00AB → mem_req after 2 edges, mem_addr 0x0000_1000, mem_wdata 0xAB00_0000, mem_wstrb 4'b1000.
- sh to 0x0000_2001 → st_misalign pulses once, count stays 0, mem_req stays 0. Repeat with sb_en and sw_en both set → same response.
- Five sw pushes with mem_ack = 0 and DEPTH = 4 → st_ready = 0 after the fourth push, the fifth is not accepted, count = 4. Raise mem_ack → data 1..4 drain in order, one per cycle.
- Full buffer with simultaneous push attempt and mem_ack → pop only (st_ready was 0); the push succeeds the next cycle; count returns to 4.
- Assert rst while in ISSUE with 3 entries held → the next cycle shows mem_req = 0, count = 0, empty = 1, st_ready = 1.
- With the macro defined: push sw to 0x0000_3000, set ld_addr = 0x0000_3002 → ld_hazard = 1. After mem_ack retires the entry → ld_hazard = 0. Without the macro → ld_hazard = 0 throughout.
